// File: rtl/answer_decider_if.sv
// Sample-in / final-answer-out bundle between the sensor classifier, the answer
// decider (master) and the light-output decoder side (slave).
interface answer_decider_if;
    logic [2:0] sampleAnswer;
    logic       sampleValid;
    logic [2:0] finalAnswer;
    logic       finalDone;
    logic       busy;

    modport master (
        input  sampleAnswer,
        input  sampleValid,
        output finalAnswer,
        output finalDone,
        output busy
    );

    modport slave (
        output sampleAnswer,
        output sampleValid,
        input  finalAnswer,
        input  finalDone,
        input  busy
    );
endinterface

// File: rtl/answer_decider.sv
// Declares a final answer after MATCH_COUNT agreeing samples or NONE after WINDOW samples.
// Optional feature macro: STOP_PRIORITY_EN (a legal STOP sample reports immediately).
module answer_decider #(
    parameter int MATCH_COUNT = 4,
    parameter int WINDOW      = 16,
    parameter int HOLDOFF     = 8
) (
    input  logic              clk,
    input  logic              reset,
    answer_decider_if.master  bus
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] MATCH_V   = CW'(MATCH_COUNT);
    localparam logic [CW-1:0] WINDOW_V  = CW'(WINDOW);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [2:0]    CODE_NONE = 3'd0;
    localparam logic [2:0]    CODE_STOP = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT, S_HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cand_q, cand_d;
    logic [CW-1:0] streak_q, streak_d;
    logic [CW-1:0] win_q, win_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    answer_q, answer_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] streak_n, win_n;
    logic          rpt_en;
    logic [2:0]    rpt_code;
    logic          legal;

    assign legal = (bus.sampleAnswer <= CODE_STOP);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        win_d    = win_q;
        hold_d   = hold_q;
        answer_d = answer_q;
        streak_n = '0;
        win_n    = '0;
        rpt_en   = 1'b0;
        rpt_code = CODE_NONE;

        case (state_q)
            S_IDLE: begin
                if (bus.sampleValid && legal) begin
                    cand_d   = bus.sampleAnswer;
                    streak_d = CW'(1);
                    win_d    = CW'(1);
                    if (MATCH_COUNT == 1) begin
                        rpt_en   = 1'b1;
                        rpt_code = bus.sampleAnswer;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.sampleValid) begin
                    win_n = win_q + CW'(1);
                    if (legal) begin
                        streak_n = (bus.sampleAnswer == cand_q) ? streak_q + CW'(1) : CW'(1);
                        cand_d   = bus.sampleAnswer;
                    end else begin
                        streak_n = '0;
                    end
                    streak_d = streak_n;
                    win_d    = win_n;
                    // Agreement is checked first so it wins when it lands on the last window sample.
                    if (streak_n == MATCH_V) begin
                        rpt_en   = 1'b1;
                        rpt_code = cand_d;
                    end else if (win_n == WINDOW_V) begin
                        rpt_en   = 1'b1;
                        rpt_code = CODE_NONE;
                    end
                end
            end
            S_REPORT: begin
                streak_d = '0;
                win_d    = '0;
                hold_d   = '0;
                state_d  = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef STOP_PRIORITY_EN
        if (bus.sampleValid && (bus.sampleAnswer == CODE_STOP) && (state_q != S_REPORT)) begin
            rpt_en   = 1'b1;
            rpt_code = CODE_STOP;
        end
`endif

        if (rpt_en) begin
            state_d  = S_REPORT;
            answer_d = rpt_code;
            streak_d = '0;
            win_d    = '0;
            hold_d   = '0;
        end

        // Outputs are registered from the next state so they line up with state_q.
        done_d = (state_d == S_REPORT);
        busy_d = (state_d == S_COLLECT) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cand_q   <= '0;
            streak_q <= '0;
            win_q    <= '0;
            hold_q   <= '0;
            answer_q <= CODE_NONE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            answer_q <= answer_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.finalAnswer = answer_q;
    assign bus.finalDone   = done_q;
    assign bus.busy        = busy_q;
endmodule
